// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed, XOR-checked byte stream into imem writes.
// Latency: write strobe/addr/data registered one cycle after the 4th byte of a word.
// Backpressure: none inside a load; byte_ready is low only outside LEN_LO..CSUM.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);
  localparam int         LEN_BITS  = 8 * LEN_BYTES;
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t        state_q, state_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic [ADDR_W:0]      cnt_q, cnt_d;
  logic [1:0]           lane_q, lane_d;
  logic [23:0]          shift_q, shift_d;
  logic [7:0]           xor_q, xor_d;
  logic                 wr_en_q, wr_en_d;
  logic [31:0]          wr_addr_q, wr_addr_d;
  logic [31:0]          wr_data_q, wr_data_d;

  logic                 xfer;
  logic [LEN_BITS-1:0]  n_rx;
  logic [ADDR_W:0]      cnt_inc;

  assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CSUM);
  assign xfer       = byte_valid & byte_ready;
  assign n_rx       = {byte_data, len_lo_q};
  assign cnt_inc    = cnt_q + ONE;

  // Next-state: FSM sequencing, length check, byte packing and running XOR.
  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    shift_d   = shift_q;
    xor_d     = xor_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_LO;
          cnt_d   = '0;
          xor_d   = '0;
          lane_d  = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_lo_d = byte_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          if ((n_rx == '0) || ({1'b0, n_rx} > 17'(DEPTH))) begin
            state_d = ERROR;
          end else begin
            len_d   = n_rx[ADDR_W:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          xor_d  = xor_q ^ byte_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == LAST_LANE) begin
            // Word complete: the index is below N <= DEPTH, so it fits ADDR_W bits.
            wr_en_d   = 1'b1;
            wr_addr_d = 32'({cnt_q[ADDR_W-1:0], 2'b00});
            wr_data_d = {byte_data, shift_q};
            cnt_d     = cnt_inc;
            if (cnt_inc == len_q) state_d = CSUM;
          end else begin
            case (lane_q)
              2'd0:    shift_d[7:0]   = byte_data;
              2'd1:    shift_d[15:8]  = byte_data;
              default: shift_d[23:16] = byte_data;
            endcase
          end
        end
      end
      CSUM: begin
        if (xfer) state_d = (byte_data == xor_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also kills a write strobe due on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      shift_q   <= '0;
      xor_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      shift_q   <= shift_d;
      xor_q     <= xor_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = cnt_q;
  assign busy       = byte_ready;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign cpu_hold   = ~done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the happy path plus loads, errors and resets.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench checks byte_ready before every byte it offers.
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  int checks   = 0;
  int failures = 0;

  logic [31:0] img [DEPTH];
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // Capture every memory write seen by the (hypothetical) imem port.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic do_start(input bit with_byte);
    start      = 1'b1;
    byte_valid = with_byte;
    byte_data  = 8'h05;
    @(posedge clk); #1;
    start      = 1'b0;
    byte_valid = 1'b0;
    chk("start_state", {byte_ready, busy, done, error, cpu_hold, word_count},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0});
  endtask

  task automatic send(input logic [7:0] b, input bit exp_wr, input int gap);
    chk("ready_before_byte", byte_ready, 1'b1);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("wr_en_after_byte", wr_en, exp_wr);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      chk("wr_en_in_gap", wr_en, 1'b0);
    end
  endtask

  task automatic send_image(input int n, input int gap_max, input bit bad_csum);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] nn;
    x  = 8'h00;
    nn = 16'(n);
    wq_addr.delete();
    wq_data.delete();
    send(nn[7:0], 1'b0, 0);
    send(nn[15:8], 1'b0, 0);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) begin
        x = x ^ w[8*j +: 8];
        send(w[8*j +: 8], j == 3, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      end
    end
    send(bad_csum ? (x ^ 8'h01) : x, 1'b0, 0);
    chk("write_count", 80'(wq_addr.size()), 80'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++)
      chk("write_entry", {wq_addr[i], wq_data[i]}, {32'(4 * i), img[i]});
    if (bad_csum)
      chk("end_bad", {done, error, cpu_hold, busy, byte_ready}, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    else
      chk("end_good", {done, error, cpu_hold, busy, byte_ready, word_count},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'(n)});
  endtask

  task automatic bad_len(input logic [7:0] lo, input logic [7:0] hi);
    wq_addr.delete();
    send(lo, 1'b0, 0);
    send(hi, 1'b0, 0);
    chk("bad_len_state", {error, done, cpu_hold, busy, byte_ready}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("bad_len_no_write", 80'(wq_addr.size()), 80'd0);
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [8:0]  cnt;
    logic        bsy;
    logic        dn;
    logic        err;
    logic        hold;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_values", {byte_ready, wr_en, busy, done, error, cpu_hold, word_count, wr_addr, wr_data},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 32'd0, 32'd0});
    rst = 1'b0;
    @(posedge clk); #1;

    // Happy path N=2, one row per cycle.
    tbl[0]  = '{1, 0, 8'h00, 1, 0, 32'h0, 32'h0,        9'd0, 1, 0, 0, 1};
    tbl[1]  = '{0, 1, 8'h02, 1, 0, 32'h0, 32'h0,        9'd0, 1, 0, 0, 1};
    tbl[2]  = '{0, 1, 8'h00, 1, 0, 32'h0, 32'h0,        9'd0, 1, 0, 0, 1};
    tbl[3]  = '{0, 1, 8'h13, 1, 0, 32'h0, 32'h0,        9'd0, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 8'h00, 1, 0, 32'h0, 32'h0,        9'd0, 1, 0, 0, 1};
    tbl[5]  = '{0, 1, 8'h50, 1, 0, 32'h0, 32'h0,        9'd0, 1, 0, 0, 1};
    tbl[6]  = '{0, 1, 8'h00, 1, 1, 32'h0, 32'h00500013, 9'd1, 1, 0, 0, 1};
    tbl[7]  = '{0, 1, 8'h93, 1, 0, 32'h0, 32'h0,        9'd1, 1, 0, 0, 1};
    tbl[8]  = '{0, 1, 8'h00, 1, 0, 32'h0, 32'h0,        9'd1, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 8'hA0, 1, 0, 32'h0, 32'h0,        9'd1, 1, 0, 0, 1};
    tbl[10] = '{0, 1, 8'h00, 1, 1, 32'h4, 32'h00A00093, 9'd2, 1, 0, 0, 1};
    tbl[11] = '{0, 1, 8'h70, 0, 0, 32'h0, 32'h0,        9'd2, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 8'h00, 0, 0, 32'h0, 32'h0,        9'd2, 0, 1, 0, 0};
    for (int r = 0; r < 13; r++) begin
      start = tbl[r].st; byte_valid = tbl[r].v; byte_data = tbl[r].d;
      @(posedge clk); #1;
      chk($sformatf("table_row%0d", r),
          {byte_ready, wr_en, word_count, busy, done, error, cpu_hold,
           tbl[r].we ? {wr_addr, wr_data} : 64'h0},
          {tbl[r].rdy, tbl[r].we, tbl[r].cnt, tbl[r].bsy, tbl[r].dn, tbl[r].err, tbl[r].hold,
           tbl[r].addr, tbl[r].data});
    end
    start = 1'b0; byte_valid = 1'b0;

    // Restart from DONE with a byte offered alongside start; a new image overwrites from 0.
    img[0] = 32'hDEADBEEF;
    do_start(1'b1);
    send_image(1, 0, 1'b0);

    // Bad checksum: both words are written, then error.
    img[0] = 32'h00500013;
    img[1] = 32'h00A00093;
    do_start(1'b0);
    send_image(2, 0, 1'b1);

    // Length bounds.
    do_start(1'b0);
    bad_len(8'h00, 8'h00);
    do_start(1'b0);
    bad_len(8'h01, 8'h01);

    // Stalled source.
    do_start(1'b0);
    send_image(2, 3, 1'b0);

    // Full-depth image; last write lands at 4*(DEPTH-1).
    for (int i = 0; i < DEPTH; i++) img[i] = 32'hA5000000 ^ (32'(i) * 32'h00010203);
    do_start(1'b0);
    send_image(DEPTH, 0, 1'b0);
    chk("depth_last_addr", wq_addr[wq_addr.size() - 1], 32'h3FC);

    // Reset mid-load, asserted together with the byte that would complete word 1.
    img[0] = 32'h00500013;
    img[1] = 32'h00A00093;
    do_start(1'b0);
    send(8'h02, 0, 0); send(8'h00, 0, 0);
    send(8'h13, 0, 0); send(8'h00, 0, 0); send(8'h50, 0, 0); send(8'h00, 1, 0);
    send(8'h93, 0, 0); send(8'h00, 0, 0); send(8'hA0, 0, 0);
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h00;
    @(posedge clk); #1;
    chk("reset_midload", {byte_ready, wr_en, busy, done, error, cpu_hold, word_count, wr_addr, wr_data},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 32'd0, 32'd0});
    rst = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    do_start(1'b0);
    send_image(2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
